// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider:
// state codes, handshake levels, operand width and a helper.
package div_unit_pkg;

   localparam int DivWidth = 32;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Two's-complement negate when neg is set, pass through otherwise.
   function automatic logic [DivWidth-1:0] cond_neg(
      input logic [DivWidth-1:0] v,
      input logic                neg
   );
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: shift in the next dividend
// bit, trial-subtract the divisor, keep or restore.
module div_step
   import div_unit_pkg::*;
(
   input  logic [DivWidth-1:0] i_rem,
   input  logic [DivWidth-1:0] i_dvd,
   input  logic [DivWidth-1:0] i_dsr,
   output logic [DivWidth-1:0] o_rem,
   output logic [DivWidth-1:0] o_dvd
);

   logic [DivWidth:0]   w_shift;
   logic [DivWidth-1:0] w_sub;
   logic                w_ge;

   assign w_shift = {i_rem, i_dvd[DivWidth-1]};
   assign w_ge    = (w_shift >= {1'b0, i_dsr});
   // When w_ge holds, the true difference is below the
   // divisor, so the low 32 bits are exact.
   assign w_sub   = w_shift[DivWidth-1:0] - i_dsr;
   assign o_rem   = w_ge ? w_sub : w_shift[DivWidth-1:0];
   assign o_dvd   = {i_dvd[DivWidth-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// 32-bit signed/unsigned restoring divider, fixed 33-edge
// latency, result {remainder, quotient} held until released.
module div_unit
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_e          r_state;
   logic [5:0]          r_cnt;
   logic [DivWidth-1:0] r_rem;
   logic [DivWidth-1:0] r_dvd;
   logic [DivWidth-1:0] r_dsr;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [63:0]         r_result;
   logic                r_ready;

   div_state_e          w_state_nxt;
   logic [5:0]          w_cnt_nxt;
   logic [DivWidth-1:0] w_rem_nxt;
   logic [DivWidth-1:0] w_dvd_nxt;
   logic [DivWidth-1:0] w_dsr_nxt;
   logic                w_neg_q_nxt;
   logic                w_neg_r_nxt;
   logic [63:0]         w_result_nxt;
   logic                w_ready_nxt;

   logic [DivWidth-1:0] w_step_rem;
   logic [DivWidth-1:0] w_step_dvd;
   logic                w_neg1;
   logic                w_neg2;

   assign w_neg1 = signed_div_i & opdata1_i[DivWidth-1];
   assign w_neg2 = signed_div_i & opdata2_i[DivWidth-1];

   div_step u_step (
      .i_rem (r_rem),
      .i_dvd (r_dvd),
      .i_dsr (r_dsr),
      .o_rem (w_step_rem),
      .o_dvd (w_step_dvd)
   );

   // Next-state and datapath updates for the divider FSM.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rem_nxt    = r_rem;
      w_dvd_nxt    = r_dvd;
      w_dsr_nxt    = r_dsr;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
      w_result_nxt = r_result;
      w_ready_nxt  = r_ready;
      unique case (r_state)
         DivFree: begin
            w_ready_nxt  = DivResultNotReady;
            w_result_nxt = '0;
            if (start_i == DivStart && !annul_i) begin
               w_cnt_nxt   = '0;
               w_rem_nxt   = '0;
               w_dvd_nxt   = cond_neg(opdata1_i, w_neg1);
               w_dsr_nxt   = cond_neg(opdata2_i, w_neg2);
               w_neg_q_nxt = w_neg1 ^ w_neg2;
               w_neg_r_nxt = w_neg1;
               w_state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
            end
         end
         DivByZero: begin
            w_result_nxt = '0;
            if (annul_i) begin
               w_state_nxt = DivFree;
               w_cnt_nxt   = '0;
               w_ready_nxt = DivResultNotReady;
            end else begin
               w_state_nxt = DivEnd;
               w_ready_nxt = DivResultReady;
            end
         end
         DivOn: begin
            if (annul_i) begin
               w_state_nxt  = DivFree;
               w_cnt_nxt    = '0;
               w_ready_nxt  = DivResultNotReady;
               w_result_nxt = '0;
            end else if (r_cnt == 6'd32) begin
               w_state_nxt  = DivEnd;
               w_ready_nxt  = DivResultReady;
               w_result_nxt = {cond_neg(r_rem, r_neg_r),
                               cond_neg(r_dvd, r_neg_q)};
            end else begin
               w_rem_nxt = w_step_rem;
               w_dvd_nxt = w_step_dvd;
               w_cnt_nxt = r_cnt + 6'd1;
            end
         end
         DivEnd: begin
            if (annul_i || start_i == DivStop) begin
               w_state_nxt  = DivFree;
               w_cnt_nxt    = '0;
               w_ready_nxt  = DivResultNotReady;
               w_result_nxt = '0;
            end
         end
         default: w_state_nxt = DivFree;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= DivFree;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dsr    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_ready  <= DivResultNotReady;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rem    <= w_rem_nxt;
         r_dvd    <= w_dvd_nxt;
         r_dsr    <= w_dsr_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
         r_result <= w_result_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divisions,
// handshake holds, annul and reset abort cases.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [63:0] res;
      int          edge_n;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
      int          hold;
   } vec_t;

   vec_t vecs[$];

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic wait_ready(input string nm);
      for (int i = 0; i < 40; i++) begin
         if (ready) break;
         @(negedge clk);
      end
      if (!ready) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=0 required=1", nm);
      end
   endtask

   task automatic push_exp(input logic [63:0] r, input int lat);
      exp_t e;
      e.res    = r;
      e.edge_n = cyc + 1 + lat;
      sb.push_back(e);
   endtask

   task automatic run_div(input vec_t v, input string nm);
      logic [63:0] snap;
      signed_div = v.sg;
      op1        = v.a;
      op2        = v.b;
      start      = 1'b1;
      push_exp(v.exp, v.lat);
      @(negedge clk);
      op1        = $urandom;
      op2        = $urandom;
      signed_div = ~v.sg;
      wait_ready(nm);
      snap = result;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold_res"}, result, snap);
         chk({nm, "_hold_rdy"}, 64'(ready), 64'd1);
      end
      start = 1'b0;
      @(negedge clk);
      chk({nm, "_drop_rdy"}, 64'(ready), 64'd0);
      chk({nm, "_drop_res"}, result, 64'd0);
   endtask

   initial begin
      int n;
      int bad;
      vec_t v;
      rst        = 1'b0;
      start      = 1'b0;
      annul      = 1'b0;
      signed_div = 1'b0;
      op1        = '0;
      op2        = '0;

      vecs.push_back('{1'b0, 32'd100, 32'd7,
                       64'h00000002_0000000E, 33, 5});
      vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'd2,
                       64'hFFFFFFFF_FFFFFFFD, 33, 0});
      vecs.push_back('{1'b1, 32'd7, 32'hFFFFFFFE,
                       64'h00000001_FFFFFFFD, 33, 0});
      vecs.push_back('{1'b0, 32'd5, 32'd0,
                       64'h0, 1, 2});
      vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF,
                       64'h00000000_80000000, 33, 0});
      vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'd1,
                       64'h00000000_FFFFFFFF, 33, 0});
      vecs.push_back('{1'b0, 32'd7, 32'hFFFFFFFF,
                       64'h00000007_00000000, 33, 0});
      vecs.push_back('{1'b0, 32'h80000000, 32'hFFFFFFFF,
                       64'h80000000_00000000, 33, 1});
      vecs.push_back('{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                       64'hFFFFFFFE_0000000E, 33, 0});
      vecs.push_back('{1'b1, 32'd5, 32'd0,
                       64'h0, 1, 0});
      vecs.push_back('{1'b0, 32'd1000000, 32'd3,
                       64'h00000001_00051615, 33, 0});

      fork
         begin : monitor
            logic prev;
            exp_t e;
            prev = 1'b0;
            forever begin
               @(negedge clk);
               if (ready && !prev) begin
                  if (sb.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_ready actual=%h required=none",
                              result);
                  end else begin
                     e = sb.pop_front();
                     chk("sb_result", result, e.res);
                     chk("sb_latency", 64'(cyc), 64'(e.edge_n));
                  end
               end
               prev = ready;
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_result", result, 64'd0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_div(vecs[i], $sformatf("vec%0d", i));

      // start released while iterating: END for one cycle only
      signed_div = 1'b0;
      op1        = 32'd50;
      op2        = 32'd6;
      start      = 1'b1;
      push_exp(64'h00000002_00000008, 33);
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_ready("early_drop");
      @(negedge clk);
      chk("early_drop_rdy", 64'(ready), 64'd0);

      // annul at edge 10 of a division
      op1   = 32'd1234;
      op2   = 32'd5;
      start = 1'b1;
      n     = cyc;
      while (cyc < n + 10) @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      bad   = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready) bad++;
         @(negedge clk);
      end
      chk("annul_no_ready", 64'(bad), 64'd0);
      run_div(vecs[0], "post_annul");

      // reset at edge 20 of a division
      op1   = 32'd999;
      op2   = 32'd4;
      start = 1'b1;
      n     = cyc;
      while (cyc < n + 20) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_on_ready", 64'(ready), 64'd0);
      chk("rst_on_result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_div(vecs[1], "post_rst_on");

      // reset while a result is being held
      v     = vecs[0];
      op1   = v.a;
      op2   = v.b;
      signed_div = v.sg;
      start = 1'b1;
      push_exp(v.exp, v.lat);
      @(negedge clk);
      wait_ready("rst_end");
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_end_ready", 64'(ready), 64'd0);
      chk("rst_end_result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_div(vecs[2], "post_rst_end");

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
